// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded lock between core and debug ports for a single-port data memory
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked,
  output logic              owner
);
  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;
  localparam logic [3:0] LMAX  = 4'(LOCK_MAX);
  localparam logic       LOCK_EN = LOCK_MAX > 1;
  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       rv0_q, rv1_q;
  logic       g_lock;
  // Grant: round-robin in ARB, only the lock holder while locked; nothing while in reset
  always_comb begin
    gnt0      = reset & ((state_q == ARB) ? req0 & (~req1 | last_q) : (state_q == LOCK0) & req0);
    gnt1      = reset & ((state_q == ARB) ? req1 & (~req0 | ~last_q) : (state_q == LOCK1) & req1);
    mem_en    = gnt0 | gnt1;
    mem_we    = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
    mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    g_lock    = gnt0 ? lock0 : lock1;
    cnt_inc   = cnt_q + 4'd1;
  end
  // Next state: enter a tenure from ARB on a locked grant, leave on unlock or when the tenure is exhausted
  always_comb begin
    state_d = (state_q == 2'd3) ? ARB : state_q;
    cnt_d   = cnt_q;
    last_d  = mem_en ? gnt1 : last_q;
    if (mem_en && state_q == ARB && g_lock && LOCK_EN) begin
      state_d = gnt1 ? LOCK1 : LOCK0;
      cnt_d   = 4'd1;
    end else if (mem_en && state_q != ARB) begin
      cnt_d   = cnt_inc;
      state_d = (!g_lock || cnt_inc == LMAX) ? ARB : state_q;
    end
  end
  // State registers; reset abandons any tenure and drops in-flight read valids
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= gnt0 & ~we0;
      rv1_q   <= gnt1 & ~we1;
    end
  end
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rdata   = mem_rdata;
  assign locked  = state_q != ARB;
  assign owner   = last_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a tenure-level reference model
module tb_dmem_arbiter;
  localparam int LM = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, locked, owner;
  logic [31:0] rdata, mem_addr, mem_wdata;
  int vec = 0, err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 0; idle();
    @(negedge clk); reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; req0 = 1; req1 = 1;
    #12;
    vec++; if ({gnt0, gnt1, mem_en} !== 3'b000) begin err++; $display("FAIL reset_gnt: got %b exp 000", {gnt0, gnt1, mem_en}); end
    vec++; if ({rvalid0, rvalid1, locked, owner} !== 4'b0001) begin err++; $display("FAIL reset_regs: got %b exp 0001", {rvalid0, rvalid1, locked, owner}); end
    @(negedge clk); reset = 1; idle();
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk); req0 = 1; we0 = 0; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF; #1;
    vec++; if ({gnt0, gnt1, mem_en, mem_we} !== 4'b1010) begin err++; $display("FAIL read_gnt: got %b exp 1010", {gnt0, gnt1, mem_en, mem_we}); end
    vec++; if (mem_addr !== 32'h10) begin err++; $display("FAIL read_addr: got %h exp 00000010", mem_addr); end
    @(negedge clk); req0 = 0; #1;
    vec++; if ({rvalid0, rvalid1, owner} !== 3'b100) begin err++; $display("FAIL read_rvalid: got %b exp 100", {rvalid0, rvalid1, owner}); end
    vec++; if (rdata !== 32'hDEADBEEF) begin err++; $display("FAIL read_rdata: got %h exp deadbeef", rdata); end
    vec++; if ({mem_en, mem_addr, mem_wdata} !== 65'd0) begin err++; $display("FAIL idle_zero: got %b %h %h exp all 0", mem_en, mem_addr, mem_wdata); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200; #1;
      vec++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin err++; $display("FAIL rr_gnt[%0d]: got %b", i, {gnt0, gnt1}); end
      vec++; if (mem_addr !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin err++; $display("FAIL rr_addr[%0d]: got %h", i, mem_addr); end
      vec++; if (owner !== 1'((i + 1) % 2)) begin err++; $display("FAIL rr_owner[%0d]: got %b exp %0d", i, owner, (i + 1) % 2); end
    end
    idle();
  endtask

  task automatic test_bounded_lock();
    do_reset();
    @(negedge clk); req0 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req0 = 1; req1 = 1; lock1 = 1; #1;
      vec++; if ({gnt0, gnt1} !== ((i < 4) ? 2'b01 : 2'b10)) begin err++; $display("FAIL blk_gnt[%0d]: got %b", i, {gnt0, gnt1}); end
      vec++; if (locked !== (i >= 1 && i <= 3)) begin err++; $display("FAIL blk_locked[%0d]: got %b", i, locked); end
    end
    idle();
  endtask

  task automatic test_early_unlock();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req0 = 1; lock0 = (i < 2); req1 = 1; lock1 = 0; #1;
      vec++; if ({gnt0, gnt1} !== ((i < 3) ? 2'b10 : 2'b01)) begin err++; $display("FAIL eul_gnt[%0d]: got %b", i, {gnt0, gnt1}); end
      vec++; if (locked !== (i == 1 || i == 2)) begin err++; $display("FAIL eul_locked[%0d]: got %b", i, locked); end
    end
    idle();
  endtask

  task automatic test_write();
    @(negedge clk); idle(); req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678; #1;
    vec++; if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0111) begin err++; $display("FAIL wr_gnt: got %b exp 0111", {gnt0, gnt1, mem_en, mem_we}); end
    vec++; if ({mem_addr, mem_wdata} !== {32'h20, 32'h12345678}) begin err++; $display("FAIL wr_bus: got %h %h exp 00000020 12345678", mem_addr, mem_wdata); end
    @(negedge clk); idle(); #1;
    vec++; if ({rvalid0, rvalid1} !== 2'b00) begin err++; $display("FAIL wr_norv: got %b exp 00", {rvalid0, rvalid1}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); req0 = 1; we0 = 0; addr0 = 32'h4; #1;
    vec++; if (gnt0 !== 1'b1) begin err++; $display("FAIL rm_gnt: got %b exp 1", gnt0); end
    #2 reset = 0;
    @(negedge clk); #1;
    vec++; if ({rvalid0, gnt0} !== 2'b00) begin err++; $display("FAIL rm_inreset: got %b exp 00", {rvalid0, gnt0}); end
    @(negedge clk); reset = 1; idle(); #1;
    vec++; if ({rvalid0, locked} !== 2'b00) begin err++; $display("FAIL rm_release: got %b exp 00", {rvalid0, locked}); end
    @(negedge clk); req1 = 1; lock1 = 1;
    @(negedge clk); #1;
    vec++; if (locked !== 1'b1) begin err++; $display("FAIL rm_lockon: got %b exp 1", locked); end
    #2 reset = 0;
    @(negedge clk); reset = 1; req0 = 1; req1 = 1; lock1 = 0; #1;
    vec++; if ({gnt0, gnt1, locked} !== 3'b100) begin err++; $display("FAIL rm_after: got %b exp 100", {gnt0, gnt1, locked}); end
    @(negedge clk); idle();
  endtask

  task automatic test_random();
    int holder = -1, tcnt = 0, win, pw = -1;
    bit mlast = 1, erv0 = 0, erv1 = 0, wl, ewe;
    logic [31:0] eaddr, ewd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!(req0 && pw != 0)) begin
        req0 = $urandom_range(0, 2) != 0; we0 = 1'($urandom); lock0 = 1'($urandom);
        addr0 = $urandom; wdata0 = $urandom;
      end
      if (!(req1 && pw != 1)) begin
        req1 = $urandom_range(0, 2) != 0; we1 = 1'($urandom); lock1 = 1'($urandom);
        addr1 = $urandom; wdata1 = $urandom;
      end
      mem_rdata = $urandom;
      #1;
      if (holder >= 0) win = ((holder == 0 && req0) || (holder == 1 && req1)) ? holder : -1;
      else if (req0 && req1) win = mlast ? 0 : 1;
      else win = req0 ? 0 : req1 ? 1 : -1;
      ewe = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
      eaddr = (win == 0) ? addr0 : (win == 1) ? addr1 : 32'd0;
      ewd = (win == 0) ? wdata0 : (win == 1) ? wdata1 : 32'd0;
      vec++;
      if ({gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1, locked, owner} !==
          {win == 0, win == 1, win >= 0, ewe, erv0, erv1, holder >= 0, mlast}) begin
        err++;
        $display("FAIL rnd_ctl[%0d]: got %b exp %b", n, {gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1, locked, owner},
                 {win == 0, win == 1, win >= 0, ewe, erv0, erv1, holder >= 0, mlast});
      end
      vec++;
      if ({mem_addr, mem_wdata, rdata} !== {eaddr, ewd, mem_rdata}) begin
        err++;
        $display("FAIL rnd_bus[%0d]: got %h %h %h exp %h %h %h", n, mem_addr, mem_wdata, rdata, eaddr, ewd, mem_rdata);
      end
      erv0 = (win == 0) && !we0;
      erv1 = (win == 1) && !we1;
      if (win >= 0) begin
        wl = (win == 0) ? lock0 : lock1;
        mlast = 1'(win);
        if (holder < 0) begin
          if (wl && LM > 1) begin holder = win; tcnt = 1; end
        end else begin
          tcnt++;
          if (!wl || tcnt == LM) holder = -1;
        end
      end
      pw = win;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_bounded_lock();
    test_early_unlock();
    test_write();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
